alu_request_arbiter: RTL
========================

# alu_request_arbiter

Round-robin arbiter and sequencer that shares one `arithmetic_logic_unit` instance between R requesters. It accepts one operation at a time over a valid/ready handshake and drives the ALU operand and operation-code inputs from registers. It captures the ALU result and returns it over a response handshake tagged with the requester index. It sits between the processor's functional clients (e.g. execute stage, address generator) and the shared ALU.

## Interface
- `N`, default 4: operand/result width; must match the ALU's `N`.
- `R`, default 2: number of requesters, R >= 2.
- `ID_W`, default `$clog2(R)`: requester index width.

- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `request_valid`  in  R  bit i: requester i presents an operation.
- `request_ready`  out  R  bit i: requester i's operation accepted this cycle.
- `request_a`  in  R*N  requester i operand A at bits [i*N +: N].
- `request_b`  in  R*N  requester i operand B at bits [i*N +: N].
- `request_operation_code`  in  2R  requester i code at bits [2i +: 2].
- `alu_a`, `alu_b`  out  N  registered operands to the ALU.
- `alu_operation_code`  out  2  registered code to the ALU.
- `alu_result`  in  N  ALU combinational result.
- `response_valid`  out  1  result available.
- `response_ready`  in  1  consumer takes the result.
- `response_result`  out  N  captured ALU result.
- `response_id`  out  ID_W  index of the requester that issued the operation.
- `busy`  out  1  high when the FSM state is not IDLE.

## Operation
- FSM states: IDLE, EXECUTE, RESPOND.
- **IDLE**
  - Search `request_valid` starting at the priority pointer, ascending, wrapping at R-1 to 0.
  - The first set bit i is granted; `request_ready` is one-hot at bit i, combinational in this cycle.
  - On the grant:
    - latch requester i's A, B and code into `alu_a`, `alu_b`, `alu_operation_code`;
    - latch i into `response_id`;
    - set pointer to (i+1) mod R;
    - go to EXECUTE.
  - With no valid bits: stay in IDLE; `request_ready` = 0; pointer unchanged.
- **EXECUTE** (one cycle)
  - ALU inputs are stable.
  - At the end of the cycle, capture `alu_result` into `response_result`; go to RESPOND.
- **RESPOND**
  - `response_valid` = 1.
  - On `response_ready` = 1: go to IDLE and clear `response_valid`.
  - Otherwise hold; `response_result` and `response_id` stay stable.
- Operation codes pass through unmodified, including 2'b11. The arbiter does not interpret them.
- Arithmetic is performed entirely by the ALU, modulo 2^N; the arbiter only registers values.
- `request_ready` is 0 in EXECUTE and RESPOND, and while `reset` is high.
- A requester may drop `request_valid` before it is granted; no state is kept for ungranted requests.
- `alu_*` registers hold their last values outside IDLE grants.

## Timing
- Reset values:
  - state IDLE, pointer 0;
  - `alu_a`, `alu_b`, `alu_operation_code`, `response_result`, `response_id` all 0;
  - `response_valid`, `busy`, `request_ready` all 0.
- Grant accepted in cycle T. Then:
  - `alu_*` show the operands in T+1 (EXECUTE);
  - `response_valid` = 1 from T+2.
- Response handshake in cycle H: IDLE in H+1, and the next grant is possible in H+1.
- Minimum issue interval: 3 cycles.
- With `response_ready` tied high, RESPOND lasts one cycle.
- Reset asserted in any state: at the next edge the FSM returns to reset values. An in-flight operation is discarded and no response is issued.
- All requesters valid continuously: grants rotate 0, 1, …, R-1, 0.
- When the pointer points to a non-requesting index, the next requesting index upward (wrapping) wins in the same cycle.

## Test plan
- **Single add.** N=4, R=2. req0 A=3, B=5, op 00 at cycle T. Expect:
  - `request_ready` = 2'b01 at T;
  - `alu_a`=3, `alu_b`=5 at T+1;
  - `response_valid`=1, `response_result`=8, `response_id`=0 at T+2.
- **Subtract wrap and code pass-through.**
  - req1 A=2, B=5, op 01 → result 4'hD, id 1.
  - Same operands with op 11 → 4'hD, and `alu_operation_code`=2'b11 during EXECUTE.
- **AND.** req0 A=4'hC, B=4'hA, op 10 → result 4'h8.
- **Contention.** Both valid continuously, `response_ready`=1. Expect:
  - grant order 0, 1, 0, 1;
  - responses every 3 cycles;
  - `response_id` alternating 0, 1, 0, 1.
- **Backpressure.** `response_ready`=0 for 4 cycles in RESPOND. Expect:
  - `response_valid`, result and id held stable;
  - `request_ready`=0 throughout;
  - a pending req1 granted in the cycle after the handshake.
- **Reset mid-operation.** Assert `reset` during EXECUTE. Expect:
  - no response;
  - all outputs 0 next cycle;
  - afterwards, with both requesting, requester 0 granted first.

Source files
------------

// File: rtl/alu_request_arbiter.sv
// Round-robin arbiter that time-shares one external ALU between R requesters.
// Grants one operation, registers its operands, and returns the ALU result over a response handshake.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | searching request_valid from the pointer; grant latches operands
// S_EXECUTE | ALU inputs stable for one cycle; result captured at its end
// S_RESPOND | response_valid high until response_ready
module alu_request_arbiter #(
    parameter int N    = 4,
    parameter int R    = 2,
    parameter int ID_W = $clog2(R)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [R-1:0]      request_valid,
    output logic [R-1:0]      request_ready,
    input  logic [R*N-1:0]    request_a,
    input  logic [R*N-1:0]    request_b,
    input  logic [2*R-1:0]    request_operation_code,
    output logic [N-1:0]      alu_a,
    output logic [N-1:0]      alu_b,
    output logic [1:0]        alu_operation_code,
    input  logic [N-1:0]      alu_result,
    output logic              response_valid,
    input  logic              response_ready,
    output logic [N-1:0]      response_result,
    output logic [ID_W-1:0]   response_id,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXECUTE = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] pointer;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic            grant_fire;
    logic [ID_W:0]   cand;

    // Rotating search: the first valid index at or above the pointer, wrapping past R-1.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < R; k++) begin
            cand = {1'b0, pointer} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(R)) begin
                cand = cand - (ID_W+1)'(R);
            end
            if (!grant_found && request_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign grant_fire = (state == S_IDLE) && !reset && grant_found;

    always_comb begin
        request_ready = '0;
        if (grant_fire) begin
            request_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (grant_fire) state_next = S_EXECUTE;
            S_EXECUTE: state_next = S_RESPOND;
            S_RESPOND: if (response_ready) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand/result registers only move on a grant or at the end of EXECUTE.
    always_ff @(posedge clock) begin
        if (reset) begin
            pointer            <= '0;
            alu_a              <= '0;
            alu_b              <= '0;
            alu_operation_code <= '0;
            response_result    <= '0;
            response_id        <= '0;
        end else begin
            if (grant_fire) begin
                alu_a              <= request_a[grant_idx*N +: N];
                alu_b              <= request_b[grant_idx*N +: N];
                alu_operation_code <= request_operation_code[grant_idx*2 +: 2];
                response_id        <= grant_idx;
                pointer            <= (grant_idx == ID_W'(R-1)) ? '0 : grant_idx + 1'b1;
            end
            if (state == S_EXECUTE) begin
                response_result <= alu_result;
            end
        end
    end

    assign response_valid = (state == S_RESPOND);
    assign busy           = (state != S_IDLE);

endmodule
